uart_xcvr: RTL and testbench

- Parametrised full-duplex UART transceiver: serialises bytes from a valid/ready input stream and deserialises line data into a validated output strobe with error flags.
- Configurable data width, parity and stop bits.
- Fully synchronous to sys_clk: the baud timing is a single-cycle clock enable, with no derived clocks.
- Sits between the board UART pins and the command/echo controller logic.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_baud_gen.sv | 28 ++
 rtl/uart_xcvr.sv | 198 +++++++++++++++++++
 tb/tb_uart_xcvr.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, FSM encodings and helpers for the UART transceiver
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;
    localparam int OVERSAMPLE  = 16;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    // Rounded sys_clk cycles per oversample tick
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    endfunction

    // Parity bit that makes the frame's count of ones match the mode
    // (zero-padded payloads do not change the result)
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: single-cycle oversample tick every DIV sys_clk cycles
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600
) (
    input  logic i_sys_clk,
    input  logic i_reset,
    output logic o_os_tick
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap    = (r_cnt == CW'(DIV - 1));
    assign o_os_tick = w_wrap;

    // Free-running divider that wraps from DIV-1 back to zero
    always_ff @(posedge i_sys_clk or negedge i_reset) begin
        if (!i_reset) r_cnt <= '0;
        else          r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/uart_xcvr.sv
// uart_xcvr: full-duplex UART with valid/ready transmit and strobed, checked receive
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 i_sys_clk,
    input  logic                 i_reset,
    input  logic                 i_uart_rxd,
    output logic                 o_uart_txd,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_rx_parity_err,
    output logic                 o_rx_frame_err
);

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);

    logic w_os_tick;
    logic w_rxd;
    logic w_par_err;

    logic [1:0]           r_sync;
    rx_state_t            r_rx_state;
    logic [3:0]           r_rx_tick;
    logic [2:0]           r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_rx_parity_err;
    logic                 r_rx_frame_err;

    tx_state_t            r_tx_state;
    logic [3:0]           r_tx_tick;
    logic [2:0]           r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_txd;
    logic                 r_tx_ready;

    uart_baud_gen #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_baud (
        .i_sys_clk (i_sys_clk),
        .i_reset   (i_reset),
        .o_os_tick (w_os_tick)
    );

    assign w_rxd     = r_sync[1];
    assign w_par_err = (PARITY != PARITY_NONE) &&
                       (r_rx_par != parity_bit(8'(r_rx_shift), PARITY));

    assign o_uart_txd      = r_txd;
    assign o_tx_ready      = r_tx_ready;
    assign o_rx_data       = r_rx_data;
    assign o_rx_valid      = r_rx_valid;
    assign o_rx_parity_err = r_rx_parity_err;
    assign o_rx_frame_err  = r_rx_frame_err;

    // Two-flop synchroniser for the asynchronous serial input, idling high
    always_ff @(posedge i_sys_clk or negedge i_reset) begin
        if (!i_reset) r_sync <= 2'b11;
        else          r_sync <= {r_sync[0], i_uart_rxd};
    end

    // Receive FSM: start-bit qualification at mid-bit, then one sample per bit period
    always_ff @(posedge i_sys_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rx_state      <= RX_IDLE;
            r_rx_tick       <= '0;
            r_rx_bit        <= '0;
            r_rx_shift      <= '0;
            r_rx_par        <= 1'b0;
            r_rx_data       <= '0;
            r_rx_valid      <= 1'b0;
            r_rx_parity_err <= 1'b0;
            r_rx_frame_err  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_os_tick) begin
                case (r_rx_state)
                    RX_IDLE: if (!w_rxd) begin
                        r_rx_state <= RX_START;
                        r_rx_tick  <= '0;
                    end
                    RX_START: begin
                        r_rx_tick <= r_rx_tick + 1'b1;
                        if (r_rx_tick == TICK_MID) begin
                            r_rx_tick  <= '0;
                            r_rx_bit   <= '0;
                            r_rx_state <= w_rxd ? RX_IDLE : RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        r_rx_tick <= r_rx_tick + 1'b1;
                        if (r_rx_tick == TICK_LAST) begin
                            r_rx_shift <= {w_rxd, r_rx_shift[DATA_BITS-1:1]};
                            r_rx_bit   <= r_rx_bit + 1'b1;
                            if (r_rx_bit == 3'(DATA_BITS - 1)) begin
                                r_rx_bit   <= '0;
                                r_rx_state <= (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
                            end
                        end
                    end
                    RX_PARITY: begin
                        r_rx_tick <= r_rx_tick + 1'b1;
                        if (r_rx_tick == TICK_LAST) begin
                            r_rx_par   <= w_rxd;
                            r_rx_state <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        r_rx_tick <= r_rx_tick + 1'b1;
                        if (r_rx_tick == TICK_LAST) begin
                            r_rx_valid      <= 1'b1;
                            r_rx_data       <= r_rx_shift;
                            r_rx_parity_err <= w_par_err;
                            r_rx_frame_err  <= !w_rxd;
                            r_rx_state      <= w_rxd ? RX_IDLE : RX_WAIT_HIGH;
                        end
                    end
                    RX_WAIT_HIGH: if (w_rxd) r_rx_state <= RX_IDLE;
                    default: r_rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    // Transmit FSM: accept in IDLE, then shift start, data, parity and stop bits per 16 ticks
    always_ff @(posedge i_sys_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_tick  <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_txd      <= 1'b1;
            r_tx_ready <= 1'b1;
        end else if (r_tx_state == TX_IDLE) begin
            if (i_tx_valid) begin
                r_tx_shift <= i_tx_data;
                r_tx_par   <= parity_bit(8'(i_tx_data), PARITY);
                r_tx_ready <= 1'b0;
                r_txd      <= 1'b0;
                r_tx_tick  <= '0;
                r_tx_state <= TX_START;
            end
        end else if (w_os_tick) begin
            r_tx_tick <= r_tx_tick + 1'b1;
            if (r_tx_tick == TICK_LAST) begin
                case (r_tx_state)
                    TX_START: begin
                        r_txd      <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bit   <= '0;
                        r_tx_state <= TX_DATA;
                    end
                    TX_DATA: begin
                        if (r_tx_bit == 3'(DATA_BITS - 1)) begin
                            r_tx_bit   <= '0;
                            r_txd      <= (PARITY != PARITY_NONE) ? r_tx_par : 1'b1;
                            r_tx_state <= (PARITY != PARITY_NONE) ? TX_PARITY : TX_STOP;
                        end else begin
                            r_txd      <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_bit   <= r_tx_bit + 1'b1;
                        end
                    end
                    TX_PARITY: begin
                        r_txd      <= 1'b1;
                        r_tx_state <= TX_STOP;
                    end
                    TX_STOP: begin
                        if (r_tx_bit == 3'(STOP_BITS - 1)) begin
                            r_tx_ready <= 1'b1;
                            r_tx_state <= TX_IDLE;
                        end else begin
                            r_tx_bit <= r_tx_bit + 1'b1;
                        end
                    end
                    default: r_tx_state <= TX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: directed, table-driven checks of the UART transceiver (8N1, 8O1, 8E1)
module tb_uart_xcvr;

    typedef struct {
        int         sel;
        logic [7:0] d;
        logic       p;
        logic [7:0] exp_d;
        logic       exp_pe;
    } rx_vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] rxd;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [2:0] txd, rdy, rval, rpe, rfe;
    logic [7:0] rdat [3];

    int         vcnt [3] = '{0, 0, 0};
    logic [7:0] vdat [3];
    logic       vpe  [3];
    logic       vfe  [3];

    int checks = 0;
    int errors = 0;

    rx_vec_t vecs [8];

    always #5 clk = ~clk;

    // index 0: 8N1 (all TX tests), 1: 8O1, 2: 8E1
    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_xcvr #(
            .CLK_HZ    (1_600_000),
            .BAUD      (10_000),
            .DATA_BITS (8),
            .PARITY    (g),
            .STOP_BITS (1)
        ) u_dut (
            .i_sys_clk       (clk),
            .i_reset         (rst_n),
            .i_uart_rxd      (rxd[g]),
            .o_uart_txd      (txd[g]),
            .i_tx_data       ((g == 0) ? tx_data : 8'h00),
            .i_tx_valid      ((g == 0) ? tx_valid : 1'b0),
            .o_tx_ready      (rdy[g]),
            .o_rx_data       (rdat[g]),
            .o_rx_valid      (rval[g]),
            .o_rx_parity_err (rpe[g]),
            .o_rx_frame_err  (rfe[g])
        );
    end

    // Count every cycle of rx_valid and capture the strobed payload and flags
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rval[k]) begin
                vcnt[k] <= vcnt[k] + 1;
                vdat[k] <= rdat[k];
                vpe[k]  <= rpe[k];
                vfe[k]  <= rfe[k];
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rx_bit(input int sel, input logic v);
        rxd[sel] = v;
        repeat (160) @(posedge clk);
        #1;
    endtask

    task automatic rx_send(input int sel, input logic [7:0] d, input logic p, input logic stop);
        rx_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) rx_bit(sel, d[i]);
        if (sel != 0) rx_bit(sel, p);
        rx_bit(sel, stop);
    endtask

    // Sends d on DUT 0 (d[0] must be 1 so the start bit's end is visible) and checks the frame
    task automatic tx_send_check(input logic [7:0] d, input logic hold);
        int n;
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
        check("tx_ready_drop", rdy[0], 0);
        check("tx_start_bit", txd[0], 0);
        n = 0;
        while (txd[0] == 1'b0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tx_start_len_151_160", (n >= 151 && n <= 160), 1);
        for (int i = 0; i < 9; i++) begin
            repeat (80) @(posedge clk);
            #1;
            check($sformatf("tx_bit%0d", i), txd[0], (i < 8) ? d[i] : 1'b1);
            repeat ((i < 8) ? 80 : 79) @(posedge clk);
        end
        #1;
        check("tx_ready_low_last", rdy[0], 0);
        @(posedge clk);
        #1;
        check("tx_ready_rise", rdy[0], 1);
    endtask

    initial begin
        int n;
        int c0;
        vecs[0] = '{2, 8'h3C, 1'b0, 8'h3C, 1'b0};
        vecs[1] = '{1, 8'h01, 1'b1, 8'h01, 1'b1};
        vecs[2] = '{2, 8'h3C, 1'b1, 8'h3C, 1'b1};
        vecs[3] = '{1, 8'h01, 1'b0, 8'h01, 1'b0};
        vecs[4] = '{1, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[5] = '{2, 8'hFF, 1'b0, 8'hFF, 1'b0};
        vecs[6] = '{2, 8'h80, 1'b0, 8'h80, 1'b1};
        vecs[7] = '{0, 8'hC3, 1'b0, 8'hC3, 1'b0};

        rst_n    = 1'b0;
        rxd      = 3'b111;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", txd, 3'b111);
        check("rst_tx_ready", rdy, 3'b111);
        check("rst_rx_valid", rval, 3'b000);
        check("rst_parity_err", rpe, 3'b000);
        check("rst_frame_err", rfe, 3'b000);
        check("rst_rx_data0", rdat[0], 8'h00);
        check("rst_rx_data1", rdat[1], 8'h00);
        check("rst_rx_data2", rdat[2], 8'h00);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // TX 8N1 0xA5
        tx_send_check(8'hA5, 1'b0);
        repeat (20) @(posedge clk);
        #1;

        // Back-to-back: valid held, next byte taken the cycle tx_ready is high
        tx_send_check(8'h81, 1'b1);
        tx_data = 8'h7E;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        check("b2b_ready_low", rdy[0], 0);
        check("b2b_start_low", txd[0], 0);
        n = 0;
        while (!rdy[0] && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_done", rdy[0], 1);

        // RX table
        for (int v = 0; v < 8; v++) begin
            int s;
            s  = vecs[v].sel;
            c0 = vcnt[s];
            rx_send(s, vecs[v].d, vecs[v].p, 1'b1);
            rx_bit(s, 1'b1);
            rx_bit(s, 1'b1);
            check($sformatf("rx%0d_strobes", v), vcnt[s] - c0, 1);
            check($sformatf("rx%0d_data", v), vdat[s], vecs[v].exp_d);
            check($sformatf("rx%0d_parity_err", v), vpe[s], vecs[v].exp_pe);
            check($sformatf("rx%0d_frame_err", v), vfe[s], 0);
        end

        // Stop bit low, line held as a break for three frame times
        c0 = vcnt[0];
        rx_send(0, 8'h55, 1'b0, 1'b0);
        repeat (4800) @(posedge clk);
        #1;
        check("brk_strobes", vcnt[0] - c0, 1);
        check("brk_frame_err", vfe[0], 1);
        check("brk_data", vdat[0], 8'h55);
        rx_bit(0, 1'b1);
        rx_bit(0, 1'b1);
        check("brk_release_quiet", vcnt[0] - c0, 1);
        rx_send(0, 8'hA3, 1'b0, 1'b1);
        rx_bit(0, 1'b1);
        rx_bit(0, 1'b1);
        check("brk_next_strobes", vcnt[0] - c0, 2);
        check("brk_next_frame_err", vfe[0], 0);
        check("brk_next_data", vdat[0], 8'hA3);

        // 50-cycle low glitch is rejected
        c0 = vcnt[0];
        rxd[0] = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rxd[0] = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        check("glitch_no_strobe", vcnt[0] - c0, 0);
        rx_send(0, 8'h5A, 1'b0, 1'b1);
        rx_bit(0, 1'b1);
        rx_bit(0, 1'b1);
        check("glitch_next_strobes", vcnt[0] - c0, 1);
        check("glitch_next_data", vdat[0], 8'h5A);

        // Reset during TX data bit 3 of 0x33
        c0 = vcnt[0];
        tx_data  = 8'h33;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (700) @(posedge clk);
        #3;
        check("mid_bit3_low", txd[0], 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_txd_high", txd[0], 1);
        check("mid_rst_ready", rdy[0], 1);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", rdy[0], 1);
        tx_send_check(8'h0F, 1'b0);
        check("post_rst_no_rx_strobe", vcnt[0] - c0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
